// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator.
// A trigger on the lowest-indexed channel with a non-zero length starts a burst of
// rpt_cfg_i+1 pulses, each len_cfg_i[ch] cycles high, separated by gap_cfg_i low cycles.
// Optional feature macro: PULSE_GEN_RETRIG_EN -- when defined, an accepted trigger while
// busy restarts the burst with freshly latched config; when undefined it is ignored.
module pulse_gen_multi #(
  parameter int unsigned NUM_TRIG = 4,
  parameter int unsigned LEN_W    = 8,
  localparam int unsigned IdW     = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_TRIG-1:0]       trig_i,
  input  logic [NUM_TRIG*LEN_W-1:0] len_cfg_i,
  input  logic [LEN_W-1:0]          gap_cfg_i,
  input  logic [LEN_W-1:0]          rpt_cfg_i,
  output logic                      dout_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [IdW-1:0]            trig_id_o
);

`ifdef PULSE_GEN_RETRIG_EN
  localparam bit RetrigEn = 1'b1;
`else
  localparam bit RetrigEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;          // latched pulse length L
  logic [LEN_W-1:0] gap_q, gap_d;          // latched gap G
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;  // high cycles left after the current one
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;  // gap cycles left after the current one
  logic [LEN_W-1:0] rpt_cnt_q, rpt_cnt_d;  // pulses left after the current one
  logic [IdW-1:0]   id_q, id_d;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sel_valid;
  logic [IdW-1:0]   sel_idx;
  logic [LEN_W-1:0] sel_len;
  logic             load;

  // Pick the lowest-index asserted channel whose length is non-zero.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_len   = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (trig_i[i] && (len_cfg_i[i*LEN_W +: LEN_W] != '0)) begin
        sel_valid = 1'b1;
        sel_idx   = IdW'(i);
        sel_len   = len_cfg_i[i*LEN_W +: LEN_W];
      end
    end
  end

  assign load = sel_valid && ((state_q == StIdle) || RetrigEn);

  // Next-state logic for the burst sequencer and its registered outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    gap_d     = gap_q;
    len_cnt_d = len_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    id_d      = id_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: ;
      StHigh: begin
        if (len_cnt_q == '0) begin
          if (rpt_cnt_q != '0) begin
            rpt_cnt_d = rpt_cnt_q - 1'b1;
            if (gap_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = gap_q - 1'b1;
            end else begin
              // Zero gap: pulses merge into one continuous high window.
              len_cnt_d = len_q - 1'b1;
            end
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          len_cnt_d = len_cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d   = StHigh;
          len_cnt_d = len_q - 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acceptance overrides everything; a restart also suppresses done of the old burst.
    if (load) begin
      state_d   = StHigh;
      len_d     = sel_len;
      gap_d     = gap_cfg_i;
      rpt_cnt_d = rpt_cfg_i;
      len_cnt_d = sel_len - 1'b1;
      gap_cnt_d = '0;
      id_d      = sel_idx;
      done_d    = 1'b0;
    end

    dout_d = (state_d == StHigh);
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      gap_q     <= '0;
      len_cnt_q <= '0;
      gap_cnt_q <= '0;
      rpt_cnt_q <= '0;
      id_q      <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      len_cnt_q <= len_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      id_q      <= id_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout_o    = dout_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign trig_id_o = id_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: a burst-schedule model checked every cycle, plus
// hand-computed waveform patterns for the directed scenarios.
module tb_pulse_gen_multi;
  localparam int NT = 4;
  localparam int LW = 8;

  logic              clk;
  logic              rst_n;
  logic [NT-1:0]     trig;
  logic [NT*LW-1:0]  len_cfg;
  logic [LW-1:0]     gap_cfg;
  logic [LW-1:0]     rpt_cfg;
  logic              dout, busy, done;
  logic [1:0]        trig_id;

  pulse_gen_multi #(.NUM_TRIG(NT), .LEN_W(LW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .trig_i    (trig),
    .len_cfg_i (len_cfg),
    .gap_cfg_i (gap_cfg),
    .rpt_cfg_i (rpt_cfg),
    .dout_o    (dout),
    .busy_o    (busy),
    .done_o    (done),
    .trig_id_o (trig_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model: a burst started at cycle s covers offsets k=1..F with
  // F=(R+1)*L+R*G; within it dout is high when (k-1) mod (L+G) < L; done at F+1.
  bit         m_active = 0;
  int         m_start, m_l, m_g, m_r, m_k, m_f, m_sel;
  logic [1:0] m_id = '0;
  logic       e_dout, e_busy, e_done;
  bit         m_idle;

  logic hist_dout [0:2047];
  logic hist_busy [0:2047];
  logic hist_done [0:2047];
  logic [1:0] hist_id [0:2047];

  always @(negedge clk) begin
    e_dout = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    m_k = 0; m_f = 0;
    if (m_active) begin
      m_k = cyc - m_start;
      m_f = (m_r + 1) * m_l + m_r * m_g;
      if (m_k >= 1 && m_k <= m_f) begin
        e_busy = 1'b1;
        e_dout = (((m_k - 1) % (m_l + m_g)) < m_l);
      end else if (m_k == m_f + 1) begin
        e_done = 1'b1;
      end
    end
    if (chk_en) begin
      chk("dout", 32'(dout), 32'(e_dout));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("trig_id", 32'(trig_id), 32'(m_id));
    end
    if (cyc < 2048) begin
      hist_dout[cyc] = dout; hist_busy[cyc] = busy;
      hist_done[cyc] = done; hist_id[cyc] = trig_id;
    end
    if (!rst_n) begin
      m_active = 0;
      m_id = '0;
    end else begin
      m_idle = !m_active || (m_k > m_f);
      m_sel = -1;
      for (int i = NT - 1; i >= 0; i--)
        if (trig[i] && len_cfg[i*LW +: LW] != 0) m_sel = i;
`ifdef PULSE_GEN_RETRIG_EN
      m_idle = 1'b1;
`endif
      if (m_sel >= 0 && m_idle) begin
        m_active = 1;
        m_start = cyc;
        m_l = int'(len_cfg[m_sel*LW +: LW]);
        m_g = int'(gap_cfg);
        m_r = int'(rpt_cfg);
        m_id = m_sel[1:0];
      end
    end
  end

  // Bits for cycles t0+1..t0+n, cycle t0+1 in the MSB of the returned field.
  function automatic logic [15:0] pat(input int which, input int t0, input int n);
    logic [15:0] r = '0;
    logic b;
    for (int k = 1; k <= n; k++) begin
      case (which)
        0: b = hist_dout[t0 + k];
        1: b = hist_busy[t0 + k];
        default: b = hist_done[t0 + k];
      endcase
      r = {r[14:0], b};
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire(input logic [NT-1:0] t, output int t0);
    trig = t;
    t0 = cyc;
    step(1);
    trig = '0;
  endtask

  task automatic set_len(input int ch, input int v);
    len_cfg[ch*LW +: LW] = LW'(v);
  endtask

  int t0, t1;

  initial begin
    rst_n = 1'b0; trig = '0; len_cfg = '0; gap_cfg = '0; rpt_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_id", 32'(trig_id), 0);
    chk_en = 1;
    step(2);

    // Single pulse, ch0 len 3
    set_len(0, 3); gap_cfg = 0; rpt_cfg = 0;
    fire(4'b0001, t0); step(7);
    chk("single_dout", 32'(pat(0, t0, 5)), 32'b11100);
    chk("single_busy", 32'(pat(1, t0, 5)), 32'b11100);
    chk("single_done", 32'(pat(2, t0, 5)), 32'b00010);
    chk("single_id", 32'(hist_id[t0 + 2]), 0);

    // Burst with gap, ch2 len 2 gap 1 rpt 2
    set_len(2, 2); gap_cfg = 1; rpt_cfg = 2;
    fire(4'b0100, t0); step(11);
    chk("burst_dout", 32'(pat(0, t0, 9)), 32'b110110110);
    chk("burst_done", 32'(pat(2, t0, 10)), 32'b0000000010);
    chk("burst_id", 32'(hist_id[t0 + 3]), 2);

    // Priority with zero-length channel masked out
    set_len(0, 0); set_len(1, 4); gap_cfg = 0; rpt_cfg = 0;
    fire(4'b0011, t0); step(7);
    chk("prio_dout", 32'(pat(0, t0, 6)), 32'b111100);
    chk("prio_id", 32'(hist_id[t0 + 1]), 1);
    set_len(1, 0);
    fire(4'b0010, t0); step(5);
    chk("zero_dout", 32'(pat(0, t0, 5)), 0);
    chk("zero_busy", 32'(pat(1, t0, 5)), 0);

    // Merged repeat, gap 0
    set_len(0, 2); gap_cfg = 0; rpt_cfg = 1;
    fire(4'b0001, t0); step(6);
    chk("merge_dout", 32'(pat(0, t0, 5)), 32'b11110);
    chk("merge_done", 32'(pat(2, t0, 5)), 32'b00001);

    // Trigger while busy
    set_len(0, 5); set_len(1, 2); gap_cfg = 0; rpt_cfg = 0;
    fire(4'b0001, t0); step(2);
    trig = 4'b0010; step(1); trig = '0; step(5);
    chk("busy_dout", 32'(pat(0, t0, 6)), 32'b111110);
    chk("busy_done", 32'(pat(2, t0, 6)), 32'b000001);
`ifdef PULSE_GEN_RETRIG_EN
    chk("busy_id", 32'(hist_id[t0 + 6]), 1);
`else
    chk("busy_id", 32'(hist_id[t0 + 6]), 0);
`endif

    // Reset mid-burst
    set_len(0, 6);
    fire(4'b0001, t0); step(2);
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(4);
    chk("rst_mid_dout", 32'(pat(0, t0, 6)), 32'b111000);
    chk("rst_mid_busy", 32'(pat(1, t0, 6)), 32'b111000);
    chk("rst_mid_done", 32'(pat(2, t0, 8)), 0);
    set_len(2, 2);
    fire(4'b0100, t0); step(4);
    chk("post_rst_dout", 32'(pat(0, t0, 3)), 32'b110);
    chk("post_rst_done", 32'(pat(2, t0, 3)), 32'b001);

    // Re-trigger in the cycle done is high
    set_len(0, 2);
    fire(4'b0001, t0); step(2);
    fire(4'b0001, t1); step(5);
    chk("b2b_dout", 32'(pat(0, t0, 6)), 32'b110110);
    chk("b2b_done", 32'(pat(2, t0, 6)), 32'b001001);

    // Single-cycle pulses with wide gap on ch3
    set_len(3, 1); gap_cfg = 3; rpt_cfg = 3;
    fire(4'b1000, t0); step(15);
    chk("gap_dout", 32'(pat(0, t0, 14)), 32'b10001000100010);
    chk("gap_done", 32'(pat(2, t0, 14)), 32'b00000000000001);

    // Maximum length, two merged pulses
    set_len(3, 255); gap_cfg = 0; rpt_cfg = 1;
    fire(4'b1000, t0); step(512);
    chk("max_last_high", 32'(hist_dout[t0 + 510]), 1);
    chk("max_after", 32'(hist_dout[t0 + 511]), 0);
    chk("max_done", 32'(hist_done[t0 + 511]), 1);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
